// File: rtl/rr_mux_pkg.sv
// Shared types and sizes for the 4:1 round-robin collector.
package rr_mux_pkg;
  localparam int CH_N  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;
  typedef logic [SEL_W-1:0] ch_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/rr_arb_mux_pick4.sv
// Rotating-priority picker: first requester found searching ptr, ptr+1, ... mod 4.
module rr_pick4
  import rr_mux_pkg::*;
(
  input  logic [CH_N-1:0] req,
  input  ch_t             ptr,
  output ch_t             gnt_idx,
  output logic            any
);
  ch_t idx;

  // Walk from the far end back to ptr so the closest requester wins last.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = CH_N-1; k >= 0; k--) begin
      idx = ptr + ch_t'(k);
      if (req[idx]) begin
        gnt_idx = idx;
        any     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_arb_mux.sv
// 4:1 round-robin collector with a single registered output slot.
// Optional per-channel saturating grant counters under `RR_MUX_CNT_EN.
module rr_arb_mux
  import rr_mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CH_N-1:0]        in_valid,
  input  logic [CH_N*DATA_W-1:0] in_data,
  output logic [CH_N-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready
`ifdef RR_MUX_CNT_EN
  ,
  output logic [CH_N*CNT_W-1:0]  grant_cnt
`endif
);
  state_t            state_q, state_d;
  ch_t               ptr_q, ptr_d;
  ch_t               sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [DATA_W-1:0] ch_data [CH_N];
  ch_t               gnt;
  logic              any, load, xfer;

  for (genvar i = 0; i < CH_N; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*DATA_W +: DATA_W];
  end

  rr_pick4 u_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (gnt),
    .any     (any)
  );

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign load      = (state_q == ST_EMPTY) | (out_ready & out_valid);
  // Gate with rst_n so nothing is acknowledged upstream while in reset.
  assign xfer      = load & any & rst_n;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer) begin
          state_d = ST_FULL;
          data_d  = ch_data[gnt];
          sel_d   = gnt;
          ptr_d   = gnt + ch_t'(1);
        end
      end
      ST_FULL: begin
        if (xfer) begin
          data_d = ch_data[gnt];
          sel_d  = gnt;
          ptr_d  = gnt + ch_t'(1);
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

`ifdef RR_MUX_CNT_EN
  for (genvar i = 0; i < CH_N; i++) begin : g_cnt
    cnt_t cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (xfer && (gnt == ch_t'(i)) && (cnt_q != '1)) cnt_d = cnt_q + cnt_t'(1);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
`endif
endmodule

// File: tb/tb_rr_arb_mux.sv
// Randomized scoreboard bench for rr_arb_mux against a queue-based reference model.
module tb_rr_arb_mux;
  import rr_mux_pkg::*;
  localparam int DATA_W = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [3:0]             in_valid = '0;
  logic [4*DATA_W-1:0]    in_data = '0;
  logic [3:0]             in_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [1:0]             out_sel;
  logic                   out_ready = 1'b0;
`ifdef RR_MUX_CNT_EN
  logic [31:0]            grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    int         s;
  } exp_t;

  exp_t q[$];
  int   m_ptr  = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  rr_arb_mux #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef RR_MUX_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // One clock of stimulus. The model slot is full exactly when q holds an entry.
  task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic r);
    int         g;
    bit         hit;
    logic [3:0] er;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    g   = 0;
    hit = 1'b0;
    for (int k = 0; k < 4; k++)
      if (!hit && v[(m_ptr + k) % 4]) begin
        hit = 1'b1;
        g   = (m_ptr + k) % 4;
      end
    er = '0;
    if (hit && (q.size() == 0 || r)) er[g] = 1'b1;
    chk("in_ready", {28'd0, in_ready}, {28'd0, er});
    #2;
    if (er != 0) begin
      q.push_back('{d[g*8 +: 8], g});
      m_ptr = (g + 1) % 4;
    end
  endtask

  task automatic do_reset(input int n, input logic [3:0] v);
    @(negedge clk);
    mon_en    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = v;
    in_data   = '1;
    out_ready = 1'b1;
    #1 chk("rst_in_ready", {28'd0, in_ready}, 32'd0);
    repeat (n) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_sel", {30'd0, out_sel}, 32'd0);
    q.delete();
    m_ptr    = 0;
    in_valid = '0;
    rst_n    = 1'b1;
    mon_en   = 1'b1;
  endtask

  // Monitor: checks slot occupancy and pops the expected word on each handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (out_valid && out_ready && q.size() != 0) begin
          e = q.pop_front();
          chk("out_data", {24'd0, out_data}, {24'd0, e.d});
          chk("out_sel", {30'd0, out_sel}, e.s);
        end
      end
    end
  end

  initial begin
    // Reset with all channels requesting.
    do_reset(2, 4'b1111);

    // Single request on ch2.
    cycle(4'b0100, 32'h00A5_0000, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);

    // Saturated load straight after reset: 0,1,2,3,0,1.
    do_reset(1, 4'b0000);
    for (int i = 0; i < 6; i++) cycle(4'b1111, $urandom, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);

    // Backpressure with ch1 word held, then drain + load of ch2 together.
    do_reset(1, 4'b0000);
    cycle(4'b0010, 32'h0000_3C00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, $urandom, 1'b0);
      chk("bp_hold_data", {24'd0, out_data}, 32'h3C);
      chk("bp_hold_sel", {30'd0, out_sel}, 32'd1);
    end
    cycle(4'b1111, 32'h7766_5544, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);
    chk("bp_next_sel", {30'd0, out_sel}, 32'd2);
    chk("bp_next_data", {24'd0, out_data}, 32'h66);

    // Reset mid-operation, then first grant must be ch3.
    cycle(4'b1000, 32'h1100_0000, 1'b0);
    cycle(4'b1000, 32'h1100_0000, 1'b0);
    do_reset(1, 4'b1000);
    cycle(4'b1000, 32'h9900_0000, 1'b1);
    cycle(4'b0000, 32'h0, 1'b0);
    chk("midrst_sel", {30'd0, out_sel}, 32'd3);
    chk("midrst_data", {24'd0, out_data}, 32'h99);
    cycle(4'b0000, 32'h0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++)
      cycle(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 3; i++) cycle(4'b0000, 32'h0, 1'b1);

`ifdef RR_MUX_CNT_EN
    do_reset(1, 4'b0000);
    chk("cnt_reset", grant_cnt, 32'd0);
    for (int i = 0; i < 300; i++) cycle(4'b0010, $urandom, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);
    chk("cnt_sat", grant_cnt, 32'h0000_FF00);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
